// File: rtl/data_compressor.sv
// 30-bit to 12-bit RGB Avalon-ST compressor: per-channel round/saturate, frame
// tracking on accepted beats, and a two-entry skid buffer with a registered ready.
module data_compressor #(
  parameter int INITIAL_DATA_WIDTH = 30,
  parameter int FINAL_DATA_WIDTH   = 12,
  parameter int FRAME_WIDTH        = 640,
  parameter int FRAME_HEIGHT       = 480,
  parameter int ROUND              = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INITIAL_DATA_WIDTH-1:0] data_in,
  input  logic                          sop_in,
  input  logic                          eop_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic                          ready_in,
  output logic [FINAL_DATA_WIDTH-1:0]   data_out,
  output logic                          sop_out,
  output logic                          eop_out,
  output logic                          valid_out,
  output logic                          frame_done,
  output logic                          frame_error
);

  localparam int PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int PIX_W  = $clog2(PIXELS + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS);
  // Buffered beat layout: {done, sop, eop, pixel}
  localparam int BEAT_W = FINAL_DATA_WIDTH + 3;

  typedef enum logic {WAIT_SOP, IN_FRAME} state_t;

  function automatic logic [3:0] round_chan(input logic [9:0] c);
    logic [3:0] q;
    q = c[9:6];
    if (ROUND != 0 && c[5] && q != 4'hF) q = q + 4'd1;
    return q;
  endfunction

  state_t                   state_q, state_d;
  logic [PIX_W-1:0]         pix_q, pix_d, pix_next;
  logic                     err_q, err_d;
  logic                     fwd, eop_fwd, done_fwd, accept, xfer;
  logic [FINAL_DATA_WIDTH-1:0] conv;
  logic [BEAT_W-1:0]        in_beat;
  logic [BEAT_W-1:0]        main_q, main_d, skid_q, skid_d;
  logic                     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic                     ready_q, ready_d;

  assign conv    = FINAL_DATA_WIDTH'({round_chan(data_in[29:20]),
                                      round_chan(data_in[19:10]),
                                      round_chan(data_in[9:0])});
  assign accept  = valid_in && ready_q;
  assign xfer    = main_vld_q && ready_in;
  assign in_beat = {done_fwd, sop_in, eop_fwd, conv};

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    pix_next = pix_q + PIX_W'(1);
    fwd      = 1'b0;
    eop_fwd  = eop_in;
    done_fwd = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      if (state_q == WAIT_SOP && !sop_in) begin
        err_d = 1'b1;
      end else begin
        fwd = 1'b1;
        if (sop_in) begin
          pix_next = PIX_W'(1);
          if (state_q == IN_FRAME) err_d = 1'b1;
        end
        pix_d   = pix_next;
        state_d = IN_FRAME;
        if (eop_in) begin
          state_d = WAIT_SOP;
          if (pix_next == PIX_LAST) done_fwd = 1'b1;
          else                      err_d    = 1'b1;
        end else if (pix_next == PIX_LAST) begin
          // Frame is full but eop never came: close it ourselves.
          eop_fwd = 1'b1;
          err_d   = 1'b1;
          state_d = WAIT_SOP;
        end
      end
    end
  end

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end
    if (fwd) begin
      if (!main_vld_d) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end
    end
    ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_SOP;
      pix_q      <= '0;
      err_q      <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      err_q      <= err_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_out   = ready_q;
  assign valid_out   = main_vld_q;
  assign data_out    = main_q[FINAL_DATA_WIDTH-1:0];
  assign eop_out     = main_q[FINAL_DATA_WIDTH];
  assign sop_out     = main_q[FINAL_DATA_WIDTH+1];
  assign frame_done  = xfer && main_q[FINAL_DATA_WIDTH+2];
  assign frame_error = err_q;

endmodule

// File: tb/tb_data_compressor.sv
// Bench for data_compressor: queue-based frame/pixel model checked every cycle,
// directed framing cases with literal pulse counts, then randomized traffic.
module tb_data_compressor;
  localparam int N = 4;

  typedef struct packed {
    logic [11:0] d;
    logic        s;
    logic        e;
    logic        dn;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [29:0] data_in = '0;
  logic        sop_in = 1'b0, eop_in = 1'b0, valid_in = 1'b0;
  logic        ready_force = 1'b1, ready_rnd = 1'b1, rnd_en = 1'b0;
  logic        ready_in;
  logic        ready_out, sop_out, eop_out, valid_out, frame_done, frame_error;
  logic [11:0] data_out;
  assign ready_in = rnd_en ? ready_rnd : ready_force;

  logic [29:0] d1_data = '0;
  logic        d1_sop = 1'b0, d1_eop = 1'b0, d1_valid = 1'b0, d1_ready_in = 1'b1;
  logic        d1_ready_out, d1_sop_out, d1_eop_out, d1_valid_out, d1_done, d1_err;
  logic [11:0] d1_data_out;

  data_compressor #(.FRAME_WIDTH(4), .FRAME_HEIGHT(1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_in(valid_in), .ready_out(ready_out), .ready_in(ready_in),
    .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out), .valid_out(valid_out),
    .frame_done(frame_done), .frame_error(frame_error));

  data_compressor #(.FRAME_WIDTH(1), .FRAME_HEIGHT(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(d1_data), .sop_in(d1_sop), .eop_in(d1_eop),
    .valid_in(d1_valid), .ready_out(d1_ready_out), .ready_in(d1_ready_in),
    .data_out(d1_data_out), .sop_out(d1_sop_out), .eop_out(d1_eop_out),
    .valid_out(d1_valid_out), .frame_done(d1_done), .frame_error(d1_err));

  int n_chk = 0, n_fail = 0;
  int n_err = 0, n_done = 0, n_out = 0, m_done = 0;
  logic last_eop = 1'b0;

  beat_t q[$];
  bit    in_frame = 0;
  int    cnt = 0;
  bit    exp_err = 0, ready_seen = 0, stall_prev = 0;
  logic [14:0] prev_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mconv(input int c);
    int r;
    r = (c + 32) / 64;
    if (r > 15) r = 15;
    return r[3:0];
  endfunction

  function automatic logic [11:0] mpix(input logic [29:0] d);
    return {mconv(int'(d[29:20])), mconv(int'(d[19:10])), mconv(int'(d[9:0]))};
  endfunction

  task automatic model_accept(input logic s, input logic e, input logic [29:0] d);
    beat_t b;
    if (!in_frame && !s) begin
      exp_err = 1;
      return;
    end
    if (s) begin
      if (in_frame) exp_err = 1;
      cnt = 1;
    end else begin
      cnt++;
    end
    in_frame = 1;
    b.d = mpix(d); b.s = s; b.e = e; b.dn = 1'b0;
    if (e) begin
      in_frame = 0;
      if (cnt == N) begin b.dn = 1'b1; m_done++; end
      else exp_err = 1;
    end else if (cnt == N) begin
      b.e = 1'b1; exp_err = 1; in_frame = 0;
    end
    q.push_back(b);
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("rst_valid_out", 32'(valid_out), 32'(0));
      check("rst_ready_out", 32'(ready_out), 32'(0));
      check("rst_outputs", 32'({data_out, sop_out, eop_out, frame_done, frame_error}), 32'(0));
      q.delete(); in_frame = 0; cnt = 0; exp_err = 0; ready_seen = 0; stall_prev = 0;
    end else begin
      check("ready_out", 32'(ready_out), 32'(ready_seen && q.size() < 2));
      check("valid_out", 32'(valid_out), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("data_out", 32'(data_out), 32'(q[0].d));
        check("sop_out", 32'(sop_out), 32'(q[0].s));
        check("eop_out", 32'(eop_out), 32'(q[0].e));
        check("frame_done", 32'(frame_done), 32'(ready_in && q[0].dn));
      end else begin
        check("frame_done_idle", 32'(frame_done), 32'(0));
      end
      check("frame_error", 32'(frame_error), 32'(exp_err));
      if (stall_prev)
        check("stall_hold", 32'({valid_out, sop_out, eop_out, data_out}), 32'(prev_out));
      stall_prev = valid_out && !ready_in;
      prev_out   = {valid_out, sop_out, eop_out, data_out};
      n_err  += int'(frame_error);
      n_done += int'(frame_done);
      if (valid_out && ready_in) begin
        n_out++;
        last_eop = eop_out;
        if (q.size() > 0) void'(q.pop_front());
      end
      exp_err = 0;
      if (valid_in && ready_out) model_accept(sop_in, eop_in, data_in);
      ready_seen = 1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 ready_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic s, input logic e, input logic [29:0] d);
    bit got = 0;
    sop_in = s; eop_in = e; data_in = d; valid_in = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = ready_out;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: ready_out stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic send_frame(input int len, input bit with_eop);
    for (int i = 0; i < len; i++)
      send(i == 0, with_eop && (i == len - 1), 30'($urandom));
  endtask

  task automatic drain();
    bit empty = 0;
    valid_in = 1'b0; ready_force = 1'b1;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(negedge clk);
      empty = !valid_out;
    end
    if (!empty) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: valid_out stayed 1, required 0 within 200 cycles");
    end
    idle(2);
  endtask

  task automatic d1_beat(input logic [29:0] d, input logic [11:0] expd);
    d1_data = d; d1_sop = 1'b1; d1_eop = 1'b1; d1_valid = 1'b1;
    @(negedge clk);
    check("d1_ready_out", 32'(d1_ready_out), 32'(1));
    @(posedge clk);
    #1 d1_valid = 1'b0;
    @(negedge clk);
    check("d1_valid_out", 32'(d1_valid_out), 32'(1));
    check("d1_data_out", 32'(d1_data_out), 32'(expd));
    check("d1_sop_eop", 32'({d1_sop_out, d1_eop_out}), 32'(2'b11));
    check("d1_frame_done", 32'(d1_done), 32'(1));
    @(negedge clk);
    check("d1_frame_error", 32'(d1_err), 32'(0));
    check("d1_valid_after", 32'(d1_valid_out), 32'(0));
    @(posedge clk);
    #1;
  endtask

  int e0, dn0, o0, md0;
  task automatic snap();
    e0 = n_err; dn0 = n_done; o0 = n_out; md0 = m_done;
  endtask

  initial begin
    logic [29:0] b0;
    idle(3);
    check("reset_valid", 32'(valid_out), 32'(0));
    check("reset_ready", 32'(ready_out), 32'(0));
    reset = 1'b1;
    #1 check("ready_before_edge", 32'(ready_out), 32'(0));
    @(posedge clk);
    #1 check("ready_after_edge", 32'(ready_out), 32'(1));
    idle(2);

    d1_beat({10'h3FF, 10'h020, 10'h01F}, 12'hF10);
    d1_beat({10'h3E0, 10'h060, 10'h000}, 12'hF20);

    // Missing sop then a proper frame
    snap();
    send(1'b0, 1'b0, 30'($urandom));
    send(1'b0, 1'b0, 30'($urandom));
    send_frame(4, 1);
    drain();
    check("nosop_err", 32'(n_err - e0), 32'(2));
    check("nosop_done", 32'(n_done - dn0), 32'(1));
    check("nosop_out", 32'(n_out - o0), 32'(4));

    // Short frame
    snap();
    send_frame(3, 1);
    drain();
    check("short_err", 32'(n_err - e0), 32'(1));
    check("short_done", 32'(n_done - dn0), 32'(0));
    check("short_out", 32'(n_out - o0), 32'(3));

    // Long frame without eop
    snap();
    send_frame(5, 0);
    drain();
    check("long_err", 32'(n_err - e0), 32'(2));
    check("long_done", 32'(n_done - dn0), 32'(0));
    check("long_out", 32'(n_out - o0), 32'(4));
    check("long_forced_eop", 32'(last_eop), 32'(1));

    // Backpressure
    snap();
    ready_force = 1'b0;
    b0 = {10'h155, 10'h2AA, 10'h0C0};
    send(1'b1, 1'b0, b0);
    send(1'b0, 1'b0, 30'($urandom));
    check("bp_ready_drop", 32'(ready_out), 32'(0));
    check("bp_hold_data", 32'({valid_out, data_out}), 32'({1'b1, 12'h5B3}));
    idle(1);
    ready_force = 1'b1;
    send(1'b0, 1'b0, 30'($urandom));
    send(1'b0, 1'b1, 30'($urandom));
    drain();
    check("bp_done", 32'(n_done - dn0), 32'(1));
    check("bp_out", 32'(n_out - o0), 32'(4));

    // Reset mid-frame
    ready_force = 1'b0;
    send(1'b1, 1'b0, 30'($urandom));
    check("mid_valid_before", 32'(valid_out), 32'(1));
    reset = 1'b0;
    #1 check("mid_valid_reset", 32'(valid_out), 32'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    ready_force = 1'b1;
    idle(1);
    snap();
    send_frame(4, 1);
    drain();
    check("post_reset_done", 32'(n_done - dn0), 32'(1));
    check("post_reset_err", 32'(n_err - e0), 32'(0));
    check("post_reset_out", 32'(n_out - o0), 32'(4));

    // Randomized traffic
    snap();
    rnd_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: send_frame(4, 1);
        3:       send_frame($urandom_range(1, 3), 1);
        4:       send_frame(5, 0);
        5:       begin send(1'b0, 1'($urandom), 30'($urandom)); send_frame(4, 1); end
        default: begin send_frame(2, 0); send_frame(4, 1); end
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_en = 1'b0;
    drain();
    check("rand_done_count", 32'(n_done - dn0), 32'(m_done - md0));
    check("rand_drained", 32'(valid_out), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_compressor.md
Name: data_compressor

Overview:
- Reduces a 30-bit RGB Avalon-ST video stream (10 bits/channel) to a 12-bit RGB stream (4 bits/channel) with round-to-nearest and saturation. This is the inverse direction of the 12-to-30-bit expander.
- Sits between the 30-bit video processing pipeline and the 12-bit frame buffer writer.
- Registered two-entry skid buffer, so `ready_out` is a register and never combinational from `ready_in`.
- A frame tracker enforces sop/eop framing against the configured frame size.

Parameters:
- INITIAL_DATA_WIDTH, 30, input pixel width; must be 3*10.
- FINAL_DATA_WIDTH, 12, output pixel width; must be 3*4.
- FRAME_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 480, lines per frame.
- ROUND, 1, 1 = round-to-nearest, 0 = truncate.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  30  pixel {R[29:20],G[19:10],B[9:0]}.
- sop_in  in  1  first pixel of frame.
- eop_in  in  1  last pixel of frame.
- valid_in  in  1  input beat valid.
- ready_out  out  1  block can accept an input beat.
- ready_in  in  1  downstream can accept an output beat.
- data_out  out  12  pixel {R[11:8],G[7:4],B[3:0]}.
- sop_out  out  1  first pixel of frame.
- eop_out  out  1  last pixel of frame.
- valid_out  out  1  output beat valid.
- frame_done  out  1  one-cycle pulse on the output transfer of a correctly sized frame's eop.
- frame_error  out  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; skid buffer empty; tracker in WAIT_SOP; pixel counter 0. `ready_out` rises on the first clk edge after reset deasserts.
- Handshakes:
  - Input accepted when valid_in && ready_out.
  - Output transferred when valid_out && ready_in.
  - data_out, sop_out and eop_out must stay stable while valid_out=1 and ready_in=0.
- Latency: 1 cycle from accepted input to valid_out, when the buffer is empty.
- Skid buffer: main register plus one skid register. `ready_out` is registered as !skid_full.
  - Accepting a beat while the main register is stalled fills the skid register; `ready_out` drops next cycle.
  - Throughput is 1 beat/cycle with ready_in held high.
- Channel conversion, per channel c[9:0]:
  - q = c[9:6].
  - If ROUND=1 and c[5]=1 and q!=4'hF, then q = q+1. Saturates at 4'hF and never wraps.
  - Conversion is applied before the beat enters the buffer.
- Frame tracker FSM, states WAIT_SOP and IN_FRAME, counter `pix` of width clog2(W*H+1). Rules apply to accepted input beats:
  - WAIT_SOP, sop_in=0: beat consumed and discarded (no output); frame_error pulse.
  - WAIT_SOP, sop_in=1: beat forwarded; pix=1; go to IN_FRAME. If eop_in=1 on the same beat, apply the eop rule immediately.
  - IN_FRAME, sop_in=1: forwarded; frame_error pulse; pix=1 (restart frame).
  - eop_in=1 with pix (after increment) == W*H: forwarded; frame_done pulses when that beat transfers out; go to WAIT_SOP.
  - eop_in=1 with pix != W*H: forwarded; frame_error pulse; go to WAIT_SOP.
  - IN_FRAME, pix reaches W*H without eop_in: beat forwarded with eop_out forced to 1; frame_error pulse; go to WAIT_SOP.
- frame_error pulses in the cycle after the offending beat is accepted. frame_done is aligned to the output transfer.
- Reset mid-frame: buffer contents are lost, no output beat is emitted, and the tracker returns to WAIT_SOP.

Test Plan:
- Channel conversion, single-pixel frame with W=H=1, ready_in=1, one beat data_in={10'h3FF,10'h020,10'h01F}, sop=eop=1 → one cycle later data_out=12'hF10, sop_out=eop_out=1, frame_done pulse.
- Rounding, data_in G=10'h060, R=10'h3E0, B=10'h000 → data_out=12'hF20.
- Backpressure, W=4,H=1, continuous valid_in with ready_in low for 3 cycles mid-frame:
  - ready_out drops after exactly 2 beats are buffered.
  - No beat is lost or duplicated and output order is preserved.
  - Outputs stay stable while stalled.
- Missing sop, 2 beats with sop=0 then a proper 4-pixel frame → first 2 beats dropped, 2 frame_error pulses, then 4 output beats and frame_done.
- Short/long frames, W=4,H=1:
  - eop on the 3rd pixel → frame_error, no frame_done.
  - 5 pixels without eop → 4th pixel emitted with eop_out=1 and frame_error; 5th dropped as missing sop.
- Reset mid-frame, reset low for 1 cycle while valid_out=1 → valid_out=0 immediately; the next frame processes normally from sop.
